pipe_stage_skid_register: RTL and testbench



---
 rtl/pipe_stage_skid_register.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_skid_register.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_register.sv
// ============================================================================
// Module   : pipe_stage_skid_register
// Brief    : Elastic valid/ready pipeline stage with a 2-entry skid buffer,
//            registered in_ready, flush, and optional PIPE_STAGE_PERF_EN counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid_register #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              w_acc;
  logic              w_pop;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign in_ready  = (r_state != ST_FULL) & reset_n;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any handshake; the accepted input is simply dropped.
    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_state_nxt == ST_EMPTY) begin
        // Payload is kept on a bubble; only control is zeroed.
        r_main_ctrl <= '0;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (!out_valid && (r_bubble_cycles != 32'hFFFF_FFFF))
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
`else
  assign stall_cycles  = 32'd0;
  assign bubble_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_register.sv
// ============================================================================
// Module   : tb_pipe_stage_skid_register
// Brief    : Directed self-checking bench for pipe_stage_skid_register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid_register;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [31:0]       stall_cycles;
  logic [31:0]       bubble_cycles;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
  );

  always #5 clk = ~clk;

  // Outputs are checked and inputs re-driven 1 time unit after each edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL rst_out_ctrl got=%h exp=00", out_ctrl); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0) begin
      bad++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cycles, bubble_cycles); end
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 128'(i); in_ctrl = 8'(i);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 128'(i) || out_ctrl !== 8'(i)) begin
        bad++; $display("FAIL stream_out[%0d] got v=%b d=%0h c=%h exp v=1 d=%0h c=%h", i, out_valid, out_data, out_ctrl, i, 8'(i)); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 128'hA; in_ctrl = 8'h0A;
    step();
    total++; if (out_data !== 128'hA || occupancy !== 2'd1) begin
      bad++; $display("FAIL bp_first got d=%0h occ=%0d exp d=a occ=1", out_data, occupancy); end
    out_ready = 1'b0; in_data = 128'hB; in_ctrl = 8'h0B;
    step();
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 128'hA) begin
      bad++; $display("FAIL bp_full got occ=%0d rdy=%b d=%0h exp occ=2 rdy=0 d=a", occupancy, in_ready, out_data); end
    in_data = 128'hC; in_ctrl = 8'h0C;
    step();
    total++; if (occupancy !== 2'd2 || out_data !== 128'hA) begin
      bad++; $display("FAIL bp_hold got occ=%0d d=%0h exp occ=2 d=a", occupancy, out_data); end
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 128'hB || out_ctrl !== 8'h0B || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_second got d=%0h c=%h occ=%0d rdy=%b exp d=b c=0b occ=1 rdy=1", out_data, out_ctrl, occupancy, in_ready); end
    step();
    total++; if (out_data !== 128'hC || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_third got d=%0h v=%b exp d=c v=1", out_data, out_valid); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++; $display("FAIL bp_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11; in_ctrl = 8'h5A;
    step();
    in_data = 128'h22; in_ctrl = 8'h5B;
    step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 128'h33; in_ctrl = 8'h5C;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
      bad++; $display("FAIL flush_full got occ=%0d v=%b c=%h exp occ=0 v=0 c=00", occupancy, out_valid, out_ctrl); end
    total++; if (out_data !== 128'h11) begin bad++; $display("FAIL flush_data_hold got=%0h exp=11", out_data); end
    // Flush from ONE with a same-cycle accept: the input must be discarded.
    in_valid = 1'b1; in_data = 128'h44; in_ctrl = 8'h44;
    step();
    flush = 1'b1; in_data = 128'h55; in_ctrl = 8'h55;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_one_rdy got=%b exp=1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 128'h44 || out_ctrl !== 8'h00) begin
      bad++; $display("FAIL flush_one got occ=%0d v=%b d=%0h c=%h exp occ=0 v=0 d=44 c=00", occupancy, out_valid, out_data, out_ctrl); end
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 128'h44) begin
      bad++; $display("FAIL flush_after got v=%b d=%0h exp v=0 d=44", out_valid, out_data); end
  endtask

  task automatic test_bubble_ctrl();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 128'h66; in_ctrl = 8'hFF;
    step();
    total++; if (out_valid !== 1'b1 || out_ctrl !== 8'hFF) begin
      bad++; $display("FAIL bubble_live got v=%b c=%h exp v=1 c=ff", out_valid, out_ctrl); end
    in_valid = 1'b0; in_data = 'x; in_ctrl = 'x;
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 128'h66) begin
      bad++; $display("FAIL bubble_idle got v=%b c=%h d=%0h exp v=0 c=00 d=66", out_valid, out_ctrl, out_data); end
    step();
    total++; if (out_ctrl !== 8'h00 || out_data !== 128'h66 || occupancy !== 2'd0) begin
      bad++; $display("FAIL bubble_x got c=%h d=%0h occ=%0d exp c=00 d=66 occ=0", out_ctrl, out_data, occupancy); end
    in_data = '0; in_ctrl = '0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h77; in_ctrl = 8'h07;
    step();
    in_data = 128'h88; in_ctrl = 8'h08;
    step();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 128'h0 || occupancy !== 2'd0) begin
      bad++; $display("FAIL rmid_outs got v=%b c=%h d=%0h occ=%0d exp all 0", out_valid, out_ctrl, out_data, occupancy); end
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      bad++; $display("FAIL rmid_release got rdy=%b occ=%0d exp rdy=1 occ=0", in_ready, occupancy); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall;
    logic [31:0] exp_bubble;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    step();
    reset_n = 1'b1; in_valid = 1'b1; in_data = 128'h99; in_ctrl = 8'h09;
    step();                                   // one bubble edge while loading
    in_valid = 1'b0;
    repeat (5) step();                        // five stalled edges
    out_ready = 1'b1;
    step();                                   // pop, neither counter moves
    out_ready = 1'b0;
    repeat (3) step();                        // three empty edges
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 32'd5; exp_bubble = 32'd4;
`else
    exp_stall = 32'd0; exp_bubble = 32'd0;
`endif
    total++; if (stall_cycles !== exp_stall) begin
      bad++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    total++; if (bubble_cycles !== exp_bubble) begin
      bad++; $display("FAIL perf_bubble got=%0d exp=%0d", bubble_cycles, exp_bubble); end
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    exp_bubble = 32'd5;
`endif
    total++; if (stall_cycles !== exp_stall || bubble_cycles !== exp_bubble) begin
      bad++; $display("FAIL perf_flush got=%0d/%0d exp=%0d/%0d", stall_cycles, bubble_cycles, exp_stall, exp_bubble); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble_ctrl();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
